// File: rtl/core_oci_dct_trace_capture.sv
// -----------------------------------------------------------------------------
// core_oci_dct_trace_capture
//
// Per-core debug-control-transfer (DCT) trace capture. It sits beside a CPU's
// OCI block. Non-empty DCT words (dct_count != 0) are captured into a circular
// buffer while a test runs. The block tracks the test end-of-run handshake and
// lets software or the bench drain the buffer through a pop port. Read data
// appears one cycle after the pop request.
//
// Optional feature (compile-time macro): DCT_TRACE_TIMESTAMP_EN
//   Defined:     a 16-bit free-running cycle counter is stored as the MSBs of
//                each entry. The counter is 0 at reset and wraps.
//                ENTRY_W = 16 + COUNT_W + DATA_W.
//   Not defined: no counter. ENTRY_W = COUNT_W + DATA_W.
//
// Parameters
//   DATA_W     width of dct_buffer
//   COUNT_W    width of dct_count
//   DEPTH      number of buffer entries (power of 2, >= 2)
//   OVERWRITE  1: a full buffer drops its oldest entry to make room
//              0: a full buffer drops the incoming word
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   synchronous, active-high
//   dct_valid       in   dct_buffer/dct_count valid this cycle
//   dct_buffer      in   DCT payload
//   dct_count       in   DCT count; 0 marks an empty word, which is never stored
//   test_ending     in   test is ending; stop capturing
//   test_has_ended  in   test has ended; completion is allowed
//   rd_req          in   pop request
//   rd_data         out  popped entry {[ts,] dct_count, dct_buffer}
//   rd_valid        out  one-cycle pulse that qualifies rd_data
//   fill_level      out  number of entries held, 0..DEPTH
//   overflow        out  sticky; set once any entry has been discarded
//   drop_count      out  number of discarded entries, saturating
//   state           out  0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//   done            out  state == DONE
// -----------------------------------------------------------------------------
module core_oci_dct_trace_capture #(
    parameter int DATA_W    = 30,
    parameter int COUNT_W   = 4,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
`ifdef DCT_TRACE_TIMESTAMP_EN
    localparam int TS_W     = 16,
`else
    localparam int TS_W     = 0,
`endif
    localparam int ENTRY_W  = TS_W + COUNT_W + DATA_W,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dct_valid,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [COUNT_W-1:0] dct_count,
    input  logic               test_ending,
    input  logic               test_has_ended,
    input  logic               rd_req,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [AW:0]        fill_level,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic [1:0]         state,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam bit OVERWRITE_EN = (OVERWRITE != 0);

    state_t             state_q, state_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               ended_q, ended_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_q, drop_d;
    logic               rd_valid_q;
    logic [ENTRY_W-1:0] rd_data_q;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [AW:0]        fill;
    logic               empty;
    logic               full;
    logic               end_any;
    logic               accept;
    logic               pop;
    logic               write_en;
    logic               drop;
    logic               rd_adv;
    logic [ENTRY_W-1:0] wr_entry;

    // ------------------------------------------------------------------
    // Optional timestamp counter
    // ------------------------------------------------------------------
`ifdef DCT_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    assign ts_d = ts_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_entry = {ts_q, dct_count, dct_buffer};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    // The pointers carry one extra wrap bit, so the difference ranges over
    // 0..DEPTH. Because DEPTH is a power of two, the MSB of the difference is
    // set only when the buffer holds exactly DEPTH entries.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign empty = (fill == '0);
    assign full  = fill[AW];

    assign end_any = test_ending | test_has_ended;

    // A word is storable only in IDLE or RUN. In IDLE an end indication wins,
    // and the block goes straight to DRAIN without storing the word. In RUN a
    // word that arrives together with the end indication is still stored.
    assign accept = dct_valid && (dct_count != '0) &&
                    ((state_q == S_RUN) || ((state_q == S_IDLE) && !end_any));

    // A pop on an empty buffer is ignored. There is no bypass from a push in
    // the same cycle.
    assign pop = rd_req && !empty;

    // When the buffer is full, a concurrent pop frees the slot that this push
    // reuses. With no pop, the policy decides which entry is lost.
    assign write_en = accept && (!full || pop || OVERWRITE_EN);
    assign drop     = accept && full && !pop;

    // A pop and an overwrite-drop cannot both occur (a drop needs !pop), so
    // the read pointer advances by at most one each cycle.
    assign rd_adv = pop || (drop && OVERWRITE_EN);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, write_en};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_adv};

    // ------------------------------------------------------------------
    // Status accumulation
    // ------------------------------------------------------------------
    always_comb begin
        ended_d    = ended_q | test_has_ended;
        overflow_d = overflow_q | drop;
        drop_d     = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM, next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (end_any) begin
                    state_d = S_DRAIN;
                end else if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (end_any) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Completion needs the end-of-test handshake, either already
                // recorded or arriving now, and an empty buffer.
                if ((ended_q || test_has_ended) && empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ended_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ended_q    <= ended_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            rd_valid_q <= pop;
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage: write port, then registered read port
    // ------------------------------------------------------------------
    // No reset on the array. Resetting the pointers is enough to discard its
    // contents.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // The read returns the value held before any write in the same cycle.
    // When the buffer is full, a push and a pop target the same slot, and
    // this ordering makes the pop return the old (oldest) entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (pop) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fill_level = fill;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign state      = state_q;
    assign done       = (state_q == S_DONE);

endmodule
